uart_frame_parser: RTL and testbench

Downstream consumer of the UART byte receiver. It takes the receiver's byte stream (`rx_data` plus the one-cycle `rx_done` strobe) and finds framed command packets of the form HDR0 HDR1 CMD LEN PAYLOAD[LEN] CSUM. It checks length and checksum, buffers the payload, and presents each good frame to the control logic through a level/ack handshake with a random-access read port. Bad, truncated or oversized frames are discarded and flagged with error pulses.

---
 rtl/uart_frame_parser.sv | 161 ++++++++++++++++
 tb/tb_uart_frame_parser.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: hunts for HDR0 HDR1 CMD LEN PAYLOAD[LEN] CSUM packets in the
// UART receiver byte stream, checks length and checksum, buffers the payload and
// holds each good frame for the control logic until it is acknowledged.
module uart_frame_parser #(
    parameter int         MAX_LEN     = 32,
    parameter int         ADDR_W      = 5,
    parameter int         TIMEOUT_CYC = 50000,
    parameter logic [7:0] HDR0        = 8'h55,
    parameter logic [7:0] HDR1        = 8'hAA
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    output logic              frame_ready,
    input  logic              frame_ack,
    output logic [7:0]        frame_cmd,
    output logic [7:0]        frame_len,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              err_csum,
    output logic              err_len,
    output logic              err_timeout,
    output logic [7:0]        drop_cnt
);

    localparam int               TMO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [8:0]       LEN_LIMIT = 9'(MAX_LEN);

    typedef enum logic [2:0] {
        S_HUNT0,
        S_HUNT1,
        S_CMD,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_HOLD
    } state_t;

    state_t            state;
    logic [7:0]        cmd_q;
    logic [7:0]        len_q;
    logic [7:0]        csum;
    logic [ADDR_W-1:0] idx;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [7:0]        buf_mem [2**ADDR_W];
    logic              tmo_run;
    logic              last_byte;

    // The inter-byte timer only matters once a frame has started and is not yet held.
    assign tmo_run   = state inside {S_HUNT1, S_CMD, S_LEN, S_PAYLOAD, S_CSUM};
    assign last_byte = (8'(idx) == len_q - 8'd1);

    // Frame FSM with registered outputs, error pulses, drop counter and timeout.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, regardless of statement order in this block.
        err_csum    <= 1'b0;
        err_len     <= 1'b0;
        err_timeout <= 1'b0;
        if (reset) begin
            state       <= S_HUNT0;
            frame_ready <= 1'b0;
            frame_cmd   <= '0;
            frame_len   <= '0;
            drop_cnt    <= '0;
            cmd_q       <= '0;
            len_q       <= '0;
            csum        <= '0;
            idx         <= '0;
            tmo_cnt     <= '0;
        end else begin
            // A byte arriving on the expiry cycle wins: the timeout needs !rx_done.
            if (rx_done || !tmo_run) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt == TMO_LAST) begin
                err_timeout <= 1'b1;
                state       <= S_HUNT0;
                tmo_cnt     <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            case (state)
                S_HUNT0: begin
                    if (rx_done && rx_data == HDR0) state <= S_HUNT1;
                end
                S_HUNT1: begin
                    if (rx_done) begin
                        if (rx_data == HDR1)      state <= S_CMD;
                        else if (rx_data != HDR0) state <= S_HUNT0;
                    end
                end
                S_CMD: begin
                    if (rx_done) begin
                        cmd_q <= rx_data;
                        csum  <= rx_data;
                        state <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (rx_done) begin
                        if ({1'b0, rx_data} > LEN_LIMIT) begin
                            err_len <= 1'b1;
                            state   <= S_HUNT0;
                        end else begin
                            len_q <= rx_data;
                            csum  <= csum + rx_data;
                            idx   <= '0;
                            state <= (rx_data == 8'd0) ? S_CSUM : S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (rx_done) begin
                        csum <= csum + rx_data;
                        idx  <= idx + ADDR_W'(1);
                        if (last_byte) state <= S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (rx_done) begin
                        if (rx_data == csum) begin
                            frame_ready <= 1'b1;
                            frame_cmd   <= cmd_q;
                            frame_len   <= len_q;
                            state       <= S_HOLD;
                        end else begin
                            err_csum <= 1'b1;
                            state    <= S_HUNT0;
                        end
                    end
                end
                S_HOLD: begin
                    // Bytes arriving while a frame is held are never parsed.
                    if (rx_done && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                    if (frame_ack) begin
                        frame_ready <= 1'b0;
                        state       <= S_HUNT0;
                    end
                end
                default: state <= S_HUNT0;
            endcase
        end
    end

    // Payload buffer write; frozen outside PAYLOAD so a held frame stays intact.
    always_ff @(posedge clk) begin
        // NOTE: the buffer RAM has no reset; readers are gated by frame_len instead.
        if (!reset && state == S_PAYLOAD && rx_done) buf_mem[idx] <= rx_data;
    end

    // Registered random-access read port, zero beyond the held frame length.
    always_ff @(posedge clk) begin
        if (reset)                                 rd_data <= '0;
        else if (32'(rd_addr) < 32'(frame_len))    rd_data <= buf_mem[rd_addr];
        else                                       rd_data <= '0;
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: directed test of the frame parser. Expected frames and
// errors are pushed to a scoreboard queue as stimulus is driven, then popped and
// compared when the parser reacts. The timeout is shortened to keep runs brief.
module tb_uart_frame_parser;

    localparam int         MAX_LEN = 32;
    localparam int         ADDR_W  = 5;
    localparam int         TMO     = 300;
    localparam logic [7:0] HDR0    = 8'h55;
    localparam logic [7:0] HDR1    = 8'hAA;

    typedef enum logic [2:0] {EV_FRAME, EV_CSUM, EV_LEN, EV_TMO, EV_NONE} ev_e;
    typedef struct packed {
        ev_e        kind;
        logic [7:0] cmd;
        logic [7:0] len;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_done;
    logic              frame_ready;
    logic              frame_ack;
    logic [7:0]        frame_cmd;
    logic [7:0]        frame_len;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              err_csum;
    logic              err_len;
    logic              err_timeout;
    logic [7:0]        drop_cnt;

    exp_t       sb_q [$];
    logic [7:0] pay_q [$];

    int n_checks = 0;
    int n_errors = 0;
    int n_csum = 0, n_len = 0, n_tmo = 0;
    int b_csum = 0, b_len = 0, b_tmo = 0;

    uart_frame_parser #(
        .MAX_LEN    (MAX_LEN),
        .ADDR_W     (ADDR_W),
        .TIMEOUT_CYC(TMO),
        .HDR0       (HDR0),
        .HDR1       (HDR1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .frame_ready(frame_ready),
        .frame_ack  (frame_ack),
        .frame_cmd  (frame_cmd),
        .frame_len  (frame_len),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .err_csum   (err_csum),
        .err_len    (err_len),
        .err_timeout(err_timeout),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    // Count high cycles of each error output, sampled on the falling edge.
    always @(negedge clk) begin
        if (err_csum)    n_csum++;
        if (err_len)     n_len++;
        if (err_timeout) n_tmo++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        b_csum = n_csum;
        b_len  = n_len;
        b_tmo  = n_tmo;
    endtask

    // Present one byte for exactly one cycle, no idle gap afterwards.
    task automatic strobe(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b);
        strobe(b);
        @(posedge clk); #1;
    endtask

    task automatic burst(input int n);
        rx_done = 1'b1;
        for (int i = 0; i < n; i++) begin
            rx_data = 8'(i * 7 + 3);
            @(posedge clk); #1;
        end
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic read_chk(input int addr, input logic [7:0] exp);
        rd_addr = ADDR_W'(addr);
        @(posedge clk); #1;
        check($sformatf("rd_data[%0d]", addr), rd_data, exp);
    endtask

    task automatic ack_frame();
        frame_ack = 1'b1;
        @(posedge clk); #1;
        frame_ack = 1'b0;
        check("ready_after_ack", frame_ready, 1'b0);
    endtask

    // Payload byte i is seed+i; the checksum is computed here, optionally corrupted.
    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len,
                              input logic [7:0] seed, input logic bad, input logic ack_mid);
        logic [7:0] sum;
        logic [7:0] b;
        mark();
        send_byte(HDR0);
        send_byte(HDR1);
        send_byte(cmd);
        if (ack_mid) begin
            frame_ack = 1'b1;
            @(posedge clk); #1;
            frame_ack = 1'b0;
        end
        if (len > 8'(MAX_LEN)) begin
            sb_q.push_back('{kind: EV_LEN, cmd: cmd, len: len});
            send_byte(len);
            return;
        end
        send_byte(len);
        sum = cmd + len;
        for (int i = 0; i < int'(len); i++) begin
            b = seed + 8'(i);
            sum = sum + b;
            if (!bad) pay_q.push_back(b);
            send_byte(b);
        end
        if (bad) begin
            sb_q.push_back('{kind: EV_CSUM, cmd: cmd, len: len});
            send_byte(sum - 8'd1);
        end else begin
            sb_q.push_back('{kind: EV_FRAME, cmd: cmd, len: len});
            send_byte(sum);
        end
    endtask

    // Pop the next expectation and compare it with what the parser produced.
    task automatic expect_next(input int budget);
        exp_t e;
        ev_e  obs;
        int   waited;
        e = sb_q.pop_front();
        obs = EV_NONE;
        waited = 0;
        while (obs == EV_NONE && waited < budget) begin
            if (frame_ready)        obs = EV_FRAME;
            else if (n_csum != b_csum) obs = EV_CSUM;
            else if (n_len != b_len)   obs = EV_LEN;
            else if (n_tmo != b_tmo)   obs = EV_TMO;
            else begin
                @(posedge clk); #1;
                waited++;
            end
        end
        check("event_kind", 32'(obs), 32'(e.kind));
        if (e.kind == EV_FRAME) begin
            if (obs == EV_FRAME) begin
                check("frame_cmd", frame_cmd, e.cmd);
                check("frame_len", frame_len, e.len);
                for (int i = 0; i < int'(e.len); i++) read_chk(i, pay_q.pop_front());
                if (int'(e.len) < MAX_LEN) read_chk(int'(e.len), 8'h00);
            end else begin
                repeat (int'(e.len)) void'(pay_q.pop_front());
            end
        end else begin
            repeat (3) @(posedge clk);
            #1;
            check("ready_after_err", frame_ready, 1'b0);
            case (e.kind)
                EV_CSUM: check("csum_pulse_cycles", 32'(n_csum - b_csum), 32'd1);
                EV_LEN:  check("len_pulse_cycles",  32'(n_len - b_len),   32'd1);
                default: check("tmo_pulse_cycles",  32'(n_tmo - b_tmo),   32'd1);
            endcase
        end
    endtask

    initial begin
        reset     = 1'b1;
        rx_data   = 8'h00;
        rx_done   = 1'b0;
        frame_ack = 1'b0;
        rd_addr   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_frame_ready", frame_ready, 1'b0);
        check("rst_frame_cmd", frame_cmd, 8'h00);
        check("rst_frame_len", frame_len, 8'h00);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_errs", {err_csum, err_len, err_timeout}, 3'b000);
        check("rst_drop_cnt", drop_cnt, 8'h00);
        reset = 1'b0;
        @(posedge clk); #1;

        // Good frame 55 AA 10 03 01 02 03 19, with an ignored ack mid-frame.
        send_frame(8'h10, 8'd3, 8'h01, 1'b0, 1'b1);
        expect_next(20);
        check("ready_before_ack", frame_ready, 1'b1);
        ack_frame();

        // Bad checksum (18), then zero-length frame 55 AA 22 00 22.
        send_frame(8'h10, 8'd3, 8'h01, 1'b1, 1'b0);
        expect_next(20);
        send_frame(8'h22, 8'd0, 8'h00, 1'b0, 1'b0);
        expect_next(20);
        ack_frame();

        // Oversize LEN=33, then resync on a repeated header byte: 55 55 AA 05 00 05.
        send_frame(8'h01, 8'd33, 8'h00, 1'b0, 1'b0);
        expect_next(20);
        send_byte(HDR0);
        send_frame(8'h05, 8'd0, 8'h00, 1'b0, 1'b0);
        expect_next(20);
        ack_frame();

        // Held-frame drops: counter increments, saturates, frame stays frozen.
        send_frame(8'h07, 8'd2, 8'hA5, 1'b0, 1'b0);
        expect_next(20);
        burst(5);
        check("drop_cnt_5", drop_cnt, 8'd5);
        burst(295);
        check("drop_cnt_sat", drop_cnt, 8'd255);
        check("held_ready", frame_ready, 1'b1);
        check("held_cmd", frame_cmd, 8'h07);
        check("held_len", frame_len, 8'd2);
        read_chk(0, 8'hA5);
        read_chk(1, 8'hA6);

        // Ack together with a HDR0 byte: the byte is dropped, not parsed.
        mark();
        rx_data   = HDR0;
        rx_done   = 1'b1;
        frame_ack = 1'b1;
        @(posedge clk); #1;
        rx_done   = 1'b0;
        frame_ack = 1'b0;
        rx_data   = 8'h00;
        check("ready_after_ack_drop", frame_ready, 1'b0);
        send_byte(HDR1);
        send_byte(8'h20);
        send_byte(8'h00);
        send_byte(8'h20);
        repeat (3) @(posedge clk);
        #1;
        check("dropped_byte_unparsed", frame_ready, 1'b0);
        check("no_err_after_drop", 32'(n_csum + n_len + n_tmo - b_csum - b_len - b_tmo), 32'd0);

        // Timeout: 55 AA 10 then silence; pulse lands exactly TMO edges after the byte.
        mark();
        send_byte(HDR0);
        send_byte(HDR1);
        sb_q.push_back('{kind: EV_TMO, cmd: 8'h10, len: 8'h00});
        strobe(8'h10);
        repeat (TMO - 1) @(posedge clk);
        #1;
        check("tmo_not_early", err_timeout, 1'b0);
        @(posedge clk); #1;
        check("tmo_on_time", err_timeout, 1'b1);
        @(posedge clk); #1;
        check("tmo_one_cycle", err_timeout, 1'b0);
        expect_next(5);

        // A byte landing on the expiry cycle suppresses the timeout.
        mark();
        send_byte(HDR0);
        send_byte(HDR1);
        strobe(8'h10);
        repeat (TMO - 1) @(posedge clk);
        #1;
        check("tmo_pre_coincide", err_timeout, 1'b0);
        strobe(8'h01);
        pay_q.push_back(8'h33);
        sb_q.push_back('{kind: EV_FRAME, cmd: 8'h10, len: 8'h01});
        @(posedge clk); #1;
        send_byte(8'h33);
        send_byte(8'h44);
        expect_next(20);
        check("tmo_suppressed", 32'(n_tmo - b_tmo), 32'd0);
        ack_frame();

        // Reset mid-payload after 55 AA 10 04 01, then a clean frame.
        mark();
        send_byte(HDR0);
        send_byte(HDR1);
        send_byte(8'h10);
        send_byte(8'h04);
        send_byte(8'h01);
        rd_addr = '0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_ready", frame_ready, 1'b0);
        check("mid_rst_cmd", frame_cmd, 8'h00);
        check("mid_rst_len", frame_len, 8'h00);
        check("mid_rst_rd_data", rd_data, 8'h00);
        check("mid_rst_drop_cnt", drop_cnt, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_no_err", 32'(n_csum + n_len + n_tmo - b_csum - b_len - b_tmo), 32'd0);
        send_frame(8'h30, 8'd2, 8'h11, 1'b0, 1'b0);
        expect_next(20);
        ack_frame();

        check("total_csum_errs", 32'(n_csum), 32'd1);
        check("total_len_errs", 32'(n_len), 32'd1);
        check("total_tmo_errs", 32'(n_tmo), 32'd1);
        check("scoreboard_drained", 32'(sb_q.size() + pay_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
